// File: rtl/outqueue_pkt_tx.sv
// Pops {fivetuple, pkt_len} entries from a fallthrough info FIFO and sends each as one AXI-Stream frame (16-byte header + counting payload).
// Latency: first beat is valid one cycle after the pop strobe; one beat per accepted cycle.
// Backpressure: beat fields are held while tvalid & ~tready; tvalid never drops mid-frame; optional stats counters under `STAT_CNT_EN.
module outqueue_pkt_tx #(
    parameter int PKT_TUPLE_WIDTH = 104,
    parameter int C_DATA_WIDTH    = 64,
    parameter int MIN_LEN         = 64,
    parameter int MAX_LEN         = 1518
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          tx_en,
    input  logic [PKT_TUPLE_WIDTH+15:0]   fifo_dout,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    output logic [C_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [31:0]                   pkt_cnt,
    output logic [47:0]                   byte_cnt
);

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_SEND = 1'b1;
    localparam int          KW      = C_DATA_WIDTH / 8;
    localparam int          HDR_W   = PKT_TUPLE_WIDTH + 24;
    localparam int          HDR_B   = HDR_W / 8;
    localparam int          HB_AW   = $clog2(HDR_B);
    localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

    logic [0:0]                 state_q, state_d;
    logic [PKT_TUPLE_WIDTH-1:0] tuple_q, tuple_d;
    logic [15:0]                len_q, len_d;
    logic [7:0]                 beat_q, beat_d;
    logic [7:0]                 last_idx_q, last_idx_d;

    logic [15:0]                clamp_len;
    logic                       accept;
    logic                       last_beat;
    logic [HDR_W-1:0]           hdr;
    logic [7:0]                 hdr_b [HDR_B];
    logic [15:0]                k;

    // Pop only from IDLE; reset gates the strobe so nothing is lost while held in reset.
    assign fifo_rd_en    = (state_q == ST_IDLE) & ~fifo_empty & tx_en & resetn;
    assign m_axis_tvalid = (state_q == ST_SEND);
    assign last_beat     = (beat_q == last_idx_q);
    assign m_axis_tlast  = m_axis_tvalid & last_beat;
    assign accept        = m_axis_tvalid & m_axis_tready;
    assign hdr           = {tuple_q, 8'h00, len_q};

    // Clamp the requested length into the legal frame range.
    always_comb begin
        clamp_len = fifo_dout[15:0];
        if (fifo_dout[15:0] < MIN_L) begin
            clamp_len = MIN_L;
        end else if (fifo_dout[15:0] > MAX_L) begin
            clamp_len = MAX_L;
        end
    end

    // Split the header into bytes, MSB first, so frame byte j is hdr_b[j].
    always_comb begin
        for (int j = 0; j < HDR_B; j++) begin
            hdr_b[j] = hdr[HDR_W-1-8*j -: 8];
        end
    end

    // Assemble the current beat: header bytes, then payload byte = low 8 bits of its frame offset.
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        k            = '0;
        if (state_q == ST_SEND) begin
            for (int i = 0; i < KW; i++) begin
                k = 16'(beat_q) * 16'(KW) + 16'(i);
                if (k < 16'(HDR_B)) begin
                    m_axis_tdata[8*i +: 8] = hdr_b[k[HB_AW-1:0]];
                end else begin
                    m_axis_tdata[8*i +: 8] = k[7:0];
                end
                m_axis_tkeep[i] = (k < len_q);
            end
        end
    end

    // Frame sequencing: latch the entry on pop, advance one beat per accepted transfer.
    always_comb begin
        state_d    = state_q;
        tuple_d    = tuple_q;
        len_d      = len_q;
        beat_d     = beat_q;
        last_idx_d = last_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_rd_en) begin
                    tuple_d    = fifo_dout[PKT_TUPLE_WIDTH+15:16];
                    len_d      = clamp_len;
                    beat_d     = 8'd0;
                    last_idx_d = 8'(((clamp_len + 16'd7) >> 3) - 16'd1);
                    state_d    = ST_SEND;
                end
            end
            default: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
        endcase
    end

    // Frame state registers; reset drops any in-flight frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tuple_q    <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            last_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            tuple_q    <= tuple_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            last_idx_q <= last_idx_d;
        end
    end

`ifdef STAT_CNT_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [47:0] byte_cnt_q, byte_cnt_d;

    // Count a frame and its clamped length when its last beat is accepted; both wrap.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (accept && last_beat) begin
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            byte_cnt_d = byte_cnt_q + 48'(len_q);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign byte_cnt = byte_cnt_q;
`else
    assign pkt_cnt  = 32'd0;
    assign byte_cnt = 48'd0;
`endif

endmodule
